// File: rtl/lms_pkg.sv
// Shared definitions for the LMS weight-update block: default widths, FSM
// state encoding and the saturation range check used by every datapath stage.
package lms_pkg;

  localparam int LMS_N        = 32;
  localparam int LMS_MU_SHIFT = 4;
  // Widest intermediate the saturation helper accepts (2*N must fit).
  localparam int LMS_MAXW     = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERR,
    ST_UPD,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HI,
    SAT_LO
  } sat_t;

  // Classifies a sign-extended value against the signed range of width w.
  function automatic sat_t sat_check(input logic signed [LMS_MAXW-1:0] v,
                                     input int w);
    logic signed [LMS_MAXW-1:0] hi;
    logic signed [LMS_MAXW-1:0] lo;
    hi = (LMS_MAXW'(1) <<< (w - 1)) - LMS_MAXW'(1);
    lo = ~hi;
    if (v > hi)      return SAT_HI;
    else if (v < lo) return SAT_LO;
    else             return SAT_NONE;
  endfunction

endpackage

// File: rtl/lms_weight_update_if.sv
// Sample handshake between the FIR stage and the weight-update block.
interface lms_weight_update_if #(
  parameter int N = lms_pkg::LMS_N
);

  logic                in_valid;
  logic                in_ready;
  logic                adapt_en;
  logic signed [N-1:0] x_in;
  logic signed [N-1:0] d_in;
  logic signed [N-1:0] y_in;

  modport master (
    output in_valid, adapt_en, x_in, d_in, y_in,
    input  in_ready
  );

  modport slave (
    input  in_valid, adapt_en, x_in, d_in, y_in,
    output in_ready
  );

endinterface

// File: rtl/lms_sat_mac.sv
// One LMS tap step: h + sat((err * x) >>> MU_SHIFT), saturated to N bits.
// Purely combinational; the caller time-shares it across taps.
module lms_sat_mac
  import lms_pkg::*;
#(
  parameter int N        = LMS_N,
  parameter int MU_SHIFT = LMS_MU_SHIFT
) (
  input  logic signed [N-1:0] h,
  input  logic signed [N-1:0] err,
  input  logic signed [N-1:0] x,
  output logic signed [N-1:0] h_next
);

  localparam logic signed [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

  function automatic logic signed [N-1:0] sat_n(input logic signed [LMS_MAXW-1:0] v);
    case (sat_check(v, N))
      SAT_HI:  return MAX_V;
      SAT_LO:  return MIN_V;
      default: return v[N-1:0];
    endcase
  endfunction

  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] step_w;
  logic signed [N-1:0]   step;
  logic signed [N:0]     sum;

  // >>> on a signed operand floors, so -1 stays -1 rather than rounding to 0.
  always_comb begin
    prod   = (2*N)'(err) * (2*N)'(x);
    step_w = prod >>> MU_SHIFT;
    step   = sat_n(LMS_MAXW'(step_w));
    sum    = (N+1)'(h) + (N+1)'(step);
    h_next = sat_n(LMS_MAXW'(sum));
  end

endmodule

// File: rtl/lms_weight_update.sv
// Three-tap LMS weight update: registers a sample, forms err = d - y, then
// updates one tap per cycle through a shared saturating MAC and tracks convergence.
module lms_weight_update
  import lms_pkg::*;
#(
  parameter int N        = LMS_N,
  parameter int MU_SHIFT = LMS_MU_SHIFT,
  parameter int H0_INIT  = 1,
  parameter int H1_INIT  = 2,
  parameter int H2_INIT  = 1,
  parameter int CONV_TOL = 8,
  parameter int CONV_CNT = 4
) (
  input  logic                clk,
  input  logic                clr_n,
  lms_weight_update_if.slave  smp,
  output logic signed [N-1:0] h0,
  output logic signed [N-1:0] h1,
  output logic signed [N-1:0] h2,
  output logic signed [N-1:0] err,
  output logic                w_valid,
  output logic                converged
);

  localparam int                  CW     = $clog2(CONV_CNT + 1);
  localparam logic [CW-1:0]       CNT_MAX = CW'(CONV_CNT);
  localparam logic signed [N-1:0] TOL_V  = N'(CONV_TOL);
  localparam logic signed [N-1:0] MAX_V  = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_V  = {1'b1, {(N-1){1'b0}}};

  function automatic logic signed [N-1:0] sat_n(input logic signed [LMS_MAXW-1:0] v);
    case (sat_check(v, N))
      SAT_HI:  return MAX_V;
      SAT_LO:  return MIN_V;
      default: return v[N-1:0];
    endcase
  endfunction

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          k;
  logic signed [N-1:0] x0, x1, x2;
  logic signed [N-1:0] d_q, y_q;
  logic                adapt_q;
  logic [CW-1:0]       conv_cnt;
  logic                accept;
  logic                near;
  logic signed [N:0]   diff;
  logic signed [N-1:0] x_sel;
  logic signed [N-1:0] h_sel;
  logic signed [N-1:0] mac_out;

  assign accept = smp.in_valid && smp.in_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_ERR;
      ST_ERR:  state_nxt = ST_UPD;
      ST_UPD:  if (k == 2'd2) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    smp.in_ready = 1'b0;
    w_valid      = 1'b0;
    case (state)
      ST_IDLE: smp.in_ready = 1'b1;
      ST_DONE: w_valid      = 1'b1;
      default: ;
    endcase
  end

  // Tap index for the UPD sweep; parked at 0 outside UPD.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)              k <= 2'd0;
    else if (state == ST_UPD) k <= k + 2'd1;
    else                     k <= 2'd0;
  end

  // ---------------- shared MAC ----------------
  always_comb begin
    x_sel = x0;
    h_sel = h0;
    case (k)
      2'd1: begin x_sel = x1; h_sel = h1; end
      2'd2: begin x_sel = x2; h_sel = h2; end
      default: ;
    endcase
  end

  lms_sat_mac #(
    .N        (N),
    .MU_SHIFT (MU_SHIFT)
  ) u_mac (
    .h      (h_sel),
    .err    (err),
    .x      (x_sel),
    .h_next (mac_out)
  );

  assign diff = (N+1)'(d_q) - (N+1)'(y_q);

  // ---------------- datapath registers ----------------
  // NOTE: the delay line and weights are individual flops, not a RAM, so they
  // all reset; an aborted update leaves nothing half-written behind.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      d_q     <= '0;
      y_q     <= '0;
      adapt_q <= 1'b0;
      err     <= '0;
      h0      <= N'(H0_INIT);
      h1      <= N'(H1_INIT);
      h2      <= N'(H2_INIT);
    end else begin
      // NOTE: non-blocking, so x1 <= x0 takes the pre-edge x0, as a shift register must.
      if (accept) begin
        x2      <= x1;
        x1      <= x0;
        x0      <= smp.x_in;
        d_q     <= smp.d_in;
        y_q     <= smp.y_in;
        adapt_q <= smp.adapt_en;
      end
      if (state == ST_ERR) err <= sat_n(LMS_MAXW'(diff));
      if (state == ST_UPD && adapt_q) begin
        case (k)
          2'd0:    h0 <= mac_out;
          2'd1:    h1 <= mac_out;
          2'd2:    h2 <= mac_out;
          default: ;
        endcase
      end
    end
  end

  // ---------------- convergence tracking ----------------
  // Range compare avoids |MIN_V| overflowing.
  assign near = (err >= -TOL_V) && (err <= TOL_V);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      conv_cnt <= '0;
    end else if (state == ST_DONE) begin
      if (!near)                  conv_cnt <= '0;
      else if (conv_cnt != CNT_MAX) conv_cnt <= conv_cnt + 1'b1;
    end
  end

  assign converged = (conv_cnt == CNT_MAX);

endmodule

// File: tb/tb_lms_weight_update.sv
// Self-checking bench for lms_weight_update: a reference model pushes expected
// err/weights/convergence per accepted sample; a monitor pops on each w_valid.
module tb_lms_weight_update;

  localparam int N = 32;

  typedef struct {
    longint err;
    longint h0;
    longint h1;
    longint h2;
    bit     conv;
  } exp_t;

  logic                clk   = 1'b0;
  logic                clr_n = 1'b1;
  logic signed [N-1:0] h0, h1, h2, err;
  logic                w_valid, converged;

  lms_weight_update_if #(.N(N)) smp ();

  lms_weight_update #(
    .N        (N),
    .MU_SHIFT (4),
    .H0_INIT  (1),
    .H1_INIT  (2),
    .H2_INIT  (1),
    .CONV_TOL (8),
    .CONV_CNT (4)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .smp       (smp),
    .h0        (h0),
    .h1        (h1),
    .h2        (h2),
    .err       (err),
    .w_valid   (w_valid),
    .converged (converged)
  );

  always #5 clk = ~clk;

  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  longint m_x[3];
  longint m_h[3];
  int     m_cnt;
  int     wv_pulses = 0;
  bit     conv_pend = 1'b0;
  bit     conv_exp  = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic model_reset();
    m_x   = '{0, 0, 0};
    m_h   = '{1, 2, 1};
    m_cnt = 0;
  endtask

  task automatic model_accept(input longint x, input longint d, input longint y, input bit a);
    exp_t   e;
    longint p;
    m_x[2] = m_x[1];
    m_x[1] = m_x[0];
    m_x[0] = x;
    e.err  = sat32(d - y);
    if (a) begin
      for (int t = 0; t < 3; t++) begin
        p      = (e.err * m_x[t]) >>> 4;
        m_h[t] = sat32(m_h[t] + sat32(p));
      end
    end
    if (e.err <= 8 && e.err >= -8) m_cnt = (m_cnt == 4) ? 4 : m_cnt + 1;
    else                           m_cnt = 0;
    e.h0   = m_h[0];
    e.h1   = m_h[1];
    e.h2   = m_h[2];
    e.conv = (m_cnt == 4);
    sb.push_back(e);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (clr_n) begin
      if (conv_pend) begin
        check("converged", longint'(converged), longint'(conv_exp));
        conv_pend = 1'b0;
      end
      if (w_valid) begin
        exp_t e;
        wv_pulses++;
        if (sb.size() == 0) begin
          check("w_valid_spurious", longint'(w_valid), 0);
        end else begin
          e = sb.pop_front();
          check("err", err, e.err);
          check("h0", h0, e.h0);
          check("h1", h1, e.h1);
          check("h2", h2, e.h2);
          conv_pend = 1'b1;
          conv_exp  = e.conv;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!smp.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", longint'(smp.in_ready), 1);
  endtask

  task automatic drive(input logic signed [N-1:0] x, input logic signed [N-1:0] d,
                       input logic signed [N-1:0] y, input bit a);
    smp.x_in     = x;
    smp.d_in     = d;
    smp.y_in     = y;
    smp.adapt_en = a;
  endtask

  task automatic send(input logic signed [N-1:0] x, input logic signed [N-1:0] d,
                      input logic signed [N-1:0] y, input bit a);
    wait_ready();
    drive(x, d, y, a);
    smp.in_valid = 1'b1;
    model_accept(x, d, y, a);
    @(posedge clk);
    #1 smp.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || conv_pend) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Caller positions time; reset is checked while still asserted.
  task automatic apply_reset(input string tag);
    clr_n = 1'b0;
    #1;
    check({tag, "_h0"}, h0, 1);
    check({tag, "_h1"}, h1, 2);
    check({tag, "_h2"}, h2, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_wv"}, longint'(w_valid), 0);
    check({tag, "_conv"}, longint'(converged), 0);
    check({tag, "_ready"}, longint'(smp.in_ready), 1);
    model_reset();
    sb.delete();
    conv_pend = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int snap;
    smp.in_valid = 1'b0;
    drive('0, '0, '0, 1'b0);
    model_reset();
    #2;
    @(negedge clk);
    apply_reset("rst");

    // Basic update with cycle-exact timing from the accept edge.
    @(negedge clk);
    drive(5, 1100, 5, 1'b1);
    smp.in_valid = 1'b1;
    model_accept(5, 1100, 5, 1'b1);
    @(posedge clk);
    #1 smp.in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t_wv_c%0d", c), longint'(w_valid), (c == 4) ? 1 : 0);
      check($sformatf("t_ready_c%0d", c), longint'(smp.in_ready), (c == 5) ? 1 : 0);
      check($sformatf("t_err_c%0d", c), err, (c >= 1) ? 1095 : 0);
      check($sformatf("t_h0_c%0d", c), h0, (c >= 2) ? 343 : 1);
      check($sformatf("t_h1_c%0d", c), h1, 2);
      check($sformatf("t_h2_c%0d", c), h2, 1);
    end
    drain();

    // Saturation of err and of the weight, both directions.
    send(1000, 32'sh7FFFFFFF, 32'sh80000000, 1'b1);
    drain();
    check("sat_err_pos", err, 64'sd2147483647);
    check("sat_h0_pos", h0, 64'sd2147483647);
    send(1000, 32'sh80000000, 32'sh7FFFFFFF, 1'b1);
    send(1000, 32'sh80000000, 32'sh7FFFFFFF, 1'b1);
    drain();
    check("sat_err_neg", err, -64'sd2147483648);
    check("sat_h0_neg", h0, -64'sd2147483648);

    // Floor shift: err=-1, x0=1 steps h0 down by one.
    @(negedge clk);
    apply_reset("rst2");
    send(1, 0, 1, 1'b1);
    drain();
    check("floor_h0", h0, 0);

    // adapt_en=0 with in_valid held high through busy cycles.
    snap = wv_pulses;
    wait_ready();
    drive(7, 50, 20, 1'b0);
    smp.in_valid = 1'b1;
    acc = 0;
    repeat (15) begin
      if (smp.in_ready) begin
        model_accept(7, 50, 20, 1'b0);
        acc++;
      end
      @(negedge clk);
    end
    smp.in_valid = 1'b0;
    drain();
    check("hold_accepts", acc, 3);
    check("hold_wv_pulses", wv_pulses - snap, 3);
    check("hold_err", err, 30);
    check("hold_h0", h0, 0);

    // Convergence: four in-tolerance samples, then one outside.
    @(negedge clk);
    apply_reset("rst3");
    send(1, 8, 0, 1'b1);
    send(2, -8, 0, 1'b1);
    send(3, 0, 0, 1'b1);
    drain();
    check("conv_after3", longint'(converged), 0);
    send(1, 3, 0, 1'b1);
    drain();
    check("conv_after4", longint'(converged), 1);
    send(1, 9, 0, 1'b1);
    drain();
    check("conv_after_err9", longint'(converged), 0);

    // Reset between E2 and E3 aborts the update.
    @(negedge clk);
    apply_reset("rst4");
    send(5, 1100, 5, 1'b1);
    repeat (3) @(negedge clk);
    check("abort_h0_pre", h0, 343);
    snap = wv_pulses;
    apply_reset("abort");
    repeat (8) @(negedge clk);
    check("abort_no_wv", wv_pulses - snap, 0);
    send(3, 100, 0, 1'b1);
    drain();
    check("abort_h1_clean", h1, 2);
    check("abort_h2_clean", h2, 1);

    // A short run of mixed samples through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      send(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 4000)) - 2000,
           int'($urandom_range(0, 4000)) - 2000, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
